// File: rtl/cordic_sched.sv
// cordic_sched: shares one fixed-latency pipelined CORDIC among NREQ requesters.
//   Round-robin issue (max one per cycle), a tag pipe carries the requester index
//   alongside the CORDIC, results land in per-requester FWFT FIFOs, and
//   per-requester credits bound the work in flight so the FIFOs cannot overflow.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_x/y/z, req_vld       operands and valid per requester (lane i at [i*W +: W])
//   req_rdy                  combinational one-hot grant (or zero)
//   cordic_x/y/z_o, _vld_o   registered issue to the CORDIC
//   cordic_x/y/z_i, _vld_i   CORDIC results, LAT cycles after issue
//   res_x/y/z, res_vld       FIFO head per requester; res_rdy pops
//   err_o                    sticky flag: CORDIC valid disagreed with tag pipe valid
// Optional: define CORDIC_SCHED_STATS_EN to add stat_issue_cnt / stat_stall_cnt
//   (NREQ x 16-bit wrapping counters of handshakes and of stalled-request cycles).
module cordic_sched #(
  parameter int NREQ       = 4,
  parameter int W          = 20,
  parameter int LAT        = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*W-1:0] req_z,
  input  logic [NREQ-1:0] req_vld,
  output logic [NREQ-1:0] req_rdy,
  output logic [W-1:0]    cordic_x_o,
  output logic [W-1:0]    cordic_y_o,
  output logic [W-1:0]    cordic_z_o,
  output logic            cordic_vld_o,
  input  logic [W-1:0]    cordic_x_i,
  input  logic [W-1:0]    cordic_y_i,
  input  logic [W-1:0]    cordic_z_i,
  input  logic            cordic_vld_i,
  output logic [NREQ*W-1:0] res_x,
  output logic [NREQ*W-1:0] res_y,
  output logic [NREQ*W-1:0] res_z,
  output logic [NREQ-1:0] res_vld,
  input  logic [NREQ-1:0] res_rdy,
  output logic            err_o
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_issue_cnt,
  output logic [NREQ*16-1:0] stat_stall_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [PW-1:0]   ptr, gnt_idx, iss_idx, cand;
  logic [NREQ-1:0] elig, gnt, push, pop;
  logic            gnt_any;
  logic [CW-1:0]   credit [NREQ];
  logic            tag_vld [LAT];
  logic [PW-1:0]   tag_idx [LAT];
  logic [3*W-1:0]  mem [NREQ][FIFO_DEPTH];
  logic [AW:0]     wr_ptr [NREQ];
  logic [AW:0]     rd_ptr [NREQ];

  // Grant is suppressed during reset so req_rdy reads zero while rst is held.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      elig[i] = ~rst & req_vld[i] & (credit[i] != '0);
  end

  // Scan from ptr upward with wrap; first eligible index wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr) + k) % NREQ);
      if (!gnt_any && elig[cand]) begin
        gnt_any   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  assign req_rdy = gnt;

  always_comb begin
    push = '0;
    if (cordic_vld_i && tag_vld[LAT-1]) push[tag_idx[LAT-1]] = 1'b1;
    pop = res_vld & res_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cordic_vld_o <= 1'b0;
      cordic_x_o   <= '0;
      cordic_y_o   <= '0;
      cordic_z_o   <= '0;
      ptr          <= '0;
      iss_idx      <= '0;
    end else begin
      cordic_vld_o <= gnt_any;
      if (gnt_any) begin
        cordic_x_o <= req_x[gnt_idx*W +: W];
        cordic_y_o <= req_y[gnt_idx*W +: W];
        cordic_z_o <= req_z[gnt_idx*W +: W];
        iss_idx    <= gnt_idx;
        ptr        <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Stage 0 captures the issue register, so stage LAT-1 lines up with cordic_vld_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_idx[k] <= '0;
      end
    end else begin
      tag_vld[0] <= cordic_vld_o;
      tag_idx[0] <= iss_idx;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                               err_o <= 1'b0;
    else if (cordic_vld_i != tag_vld[LAT-1]) err_o <= 1'b1;
  end

  // FIFO storage kept out of the reset block so it can map to plain RAM.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++)
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= {cordic_x_i, cordic_y_i, cordic_z_i};
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        credit[i] <= CW'(FIFO_DEPTH);
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({gnt[i], pop[i]})
          2'b10:   credit[i] <= credit[i] - 1'b1;
          2'b01:   credit[i] <= credit[i] + 1'b1;
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  always_comb begin
    res_x   = '0;
    res_y   = '0;
    res_z   = '0;
    res_vld = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      res_vld[i] = (wr_ptr[i] != rd_ptr[i]);
      {res_x[i*W +: W], res_y[i*W +: W], res_z[i*W +: W]} = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] issue_cnt [NREQ];
  logic [15:0] stall_cnt [NREQ];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rst) begin
        issue_cnt[i] <= '0;
        stall_cnt[i] <= '0;
      end else begin
        if (gnt[i])                issue_cnt[i] <= issue_cnt[i] + 16'd1;
        if (req_vld[i] && !gnt[i]) stall_cnt[i] <= stall_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_issue_cnt = '0;
    stat_stall_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_issue_cnt[i*16 +: 16] = issue_cnt[i];
      stat_stall_cnt[i*16 +: 16] = stall_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched. The CORDIC is modelled as a LAT-stage delay
// line returning each operand plus one; handshakes push expected results into a
// per-requester queue and a separate monitor pops and compares on every FIFO pop.
module tb_cordic_sched;
  localparam int NREQ = 4;
  localparam int W    = 20;
  localparam int LAT  = 19;
  localparam int FD   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ*W-1:0] req_x, req_y, req_z, res_x, res_y, res_z;
  logic [NREQ-1:0]   req_vld, req_rdy, res_vld, res_rdy;
  logic [W-1:0]      cx_o, cy_o, cz_o, cx_i, cy_i, cz_i;
  logic              cvld_o, cvld_i, err_o;
  logic              force_vld = 1'b0;
`ifdef CORDIC_SCHED_STATS_EN
  logic [NREQ*16-1:0] stat_issue_cnt, stat_stall_cnt;
`endif

  cordic_sched #(.NREQ(NREQ), .W(W), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_vld(req_vld), .req_rdy(req_rdy),
    .cordic_x_o(cx_o), .cordic_y_o(cy_o), .cordic_z_o(cz_o), .cordic_vld_o(cvld_o),
    .cordic_x_i(cx_i), .cordic_y_i(cy_i), .cordic_z_i(cz_i), .cordic_vld_i(cvld_i),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_vld(res_vld), .res_rdy(res_rdy),
    .err_o(err_o)
`ifdef CORDIC_SCHED_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // CORDIC stand-in: {valid, x+1, y+1, z+1} delayed LAT cycles.
  logic [3*W:0] mp [LAT];
  initial for (int k = 0; k < LAT; k++) mp[k] = '0;
  always @(posedge clk) begin
    mp[0] <= rst ? '0 : {cvld_o, cx_o + W'(1), cy_o + W'(1), cz_o + W'(1)};
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign cvld_i = mp[LAT-1][3*W] | force_vld;
  assign cx_i   = mp[LAT-1][3*W-1 -: W];
  assign cy_i   = mp[LAT-1][2*W-1 -: W];
  assign cz_i   = mp[LAT-1][W-1:0];

  int checks = 0;
  int errors = 0;
  logic [3*W-1:0] exp_q [NREQ][$];
  int grants [NREQ];
  int total_grants = 0;
  bit rr_chk = 1'b0;
  int rr_next = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Issue side: record every handshake and its expected result.
  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_onehot_gated", {63'd0, $onehot0(req_rdy) && ((req_rdy & ~req_vld) == '0)}, 64'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          exp_q[i].push_back({req_x[i*W +: W] + W'(1), req_y[i*W +: W] + W'(1), req_z[i*W +: W] + W'(1)});
          grants[i]++;
          total_grants++;
          if (rr_chk) begin
            check("rr_order", i, rr_next);
            rr_next = (i + 1) % NREQ;
          end
        end
      end
    end
  end

  // Result side: compare each popped FIFO head with the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (res_vld[i] && res_rdy[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL res_unexpected[%0d]: got %0h expected none", i, res_x[i*W +: W]);
          end else begin
            check("res_data", {res_x[i*W +: W], res_y[i*W +: W], res_z[i*W +: W]}, exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((pending() != 0 || res_vld != '0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", pending(), 0);
  endtask

  // Hold req_vld[idx] for ncyc cycles, advancing its operand after each accept.
  task automatic run_req(input int idx, input int ncyc, output int acc, output bit last_rdy);
    bit hs;
    acc = 0;
    last_rdy = 1'b0;
    req_vld[idx] = 1'b1;
    repeat (ncyc) begin
      @(negedge clk);
      hs = req_vld[idx] & req_rdy[idx];
      last_rdy = req_rdy[idx];
      @(posedge clk); #1;
      if (hs) begin
        acc++;
        req_x[idx*W +: W] = req_x[idx*W +: W] + W'(3);
      end
    end
    req_vld[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, gaps, bad;
    bit lr;
    for (int i = 0; i < NREQ; i++) grants[i] = 0;
    res_rdy = '1;
    req_vld = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = W'(16 * i + 1);
      req_y[i*W +: W] = W'(16 * i + 2);
      req_z[i*W +: W] = W'(16 * i + 3);
    end

    // Reset held with every requester asking.
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_req_rdy", req_rdy, 0);
      check("rst_cvld", cvld_o, 0);
      check("rst_res_vld", res_vld, 0);
      check("rst_err", err_o, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rr_chk = 1'b1;
    rr_next = 0;
    @(negedge clk);
    check("first_grant", req_rdy, 4'b0001);

    // Fairness: run until 40 grants; the first 16 issue back to back.
    n = 0;
    gaps = 0;
    while (total_grants < 40 && n < 300) begin
      @(negedge clk);
      if (n < 16 && !cvld_o) gaps++;
      n++;
      @(posedge clk); #1;
    end
    req_vld = '0;
    rr_chk = 1'b0;
    check("fair_bounded", {63'd0, n < 300}, 64'd1);
    check("fair_no_gap", gaps, 0);
    for (int i = 0; i < NREQ; i++) check("fair_grants", grants[i], 10);
`ifdef CORDIC_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++) check("stat_issue", stat_issue_cnt[i*16 +: 16], 10);
`endif
    drain();

    // Single request on lane 2: issue at t+1, result visible at t+21.
    req_x[2*W +: W] = 20'h08000;
    req_y[2*W +: W] = '0;
    req_z[2*W +: W] = '0;
    req_vld = 4'b0100;
    @(negedge clk);
    check("single_rdy", req_rdy, 4'b0100);
    @(posedge clk); #1;
    req_vld = '0;
    @(negedge clk);
    check("single_cvld", cvld_o, 1);
    check("single_cx", cx_o, 20'h08000);
    bad = 0;
    repeat (19) begin
      @(negedge clk);
      if (res_vld != '0) bad++;
    end
    check("single_early", bad, 0);
    @(negedge clk);
    check("single_res_vld", res_vld, 4'b0100);
    check("single_res_x", res_x[2*W +: W], 20'h08001);
    @(posedge clk); #1;
    drain();

    // Backpressure on lane 1: four credits, then one more per pop.
    res_rdy = 4'b1101;
    req_x[1*W +: W] = 20'h00100;
    run_req(1, 40, acc, lr);
    check("bp_accepted", acc, 4);
    check("bp_rdy_low", lr, 0);
    res_rdy[1] = 1'b1;
    @(posedge clk); #1;
    res_rdy[1] = 1'b0;
    run_req(1, 40, acc, lr);
    check("bp_after_pulse", acc, 1);
    res_rdy = '1;
    drain();

    // Credit corner: issue and pop on lane 0 in the same cycle.
    res_rdy[0] = 1'b0;
    run_req(0, 1, acc, lr);
    check("corner_first", acc, 1);
    repeat (25) begin @(posedge clk); #1; end
    check("corner_fifo", res_vld[0], 1);
    req_vld[0] = 1'b1;
    res_rdy[0] = 1'b1;
    @(negedge clk);
    check("corner_both", {req_rdy[0], res_vld[0]}, 2'b11);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    res_rdy[0] = 1'b0;
    run_req(0, 40, acc, lr);
    check("corner_credit", acc, 3);
    res_rdy = '1;
    drain();

    // Random traffic with random drain pressure.
    repeat (1000) begin
      req_vld = NREQ'($urandom);
      res_rdy = NREQ'($urandom);
      req_x   = (NREQ*W)'({$urandom, $urandom, $urandom});
      req_y   = (NREQ*W)'({$urandom, $urandom, $urandom});
      req_z   = (NREQ*W)'({$urandom, $urandom, $urandom});
      @(posedge clk); #1;
    end
    req_vld = '0;
    res_rdy = '1;
    drain();
    check("rand_err", err_o, 0);

    // Fault: valid from the CORDIC with an empty tag pipe.
    repeat (LAT + 3) begin @(posedge clk); #1; end
    force_vld = 1'b1;
    @(negedge clk);
    check("fault_pre", err_o, 0);
    @(posedge clk); #1;
    force_vld = 1'b0;
    @(negedge clk);
    check("fault_err", err_o, 1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (!err_o || res_vld != '0) bad++;
    end
    check("fault_sticky_nopush", bad, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("fault_cleared", err_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
